// File: rtl/pipe_stage_buf.sv
// Generic pipeline-stage register: one packed payload with valid/ready handshake,
// stall (hold) and flush (kill), plus an optional skid entry that registers in_ready.
module pipe_stage_buf #(
    parameter int          W         = 32,
    parameter logic [W-1:0] BUBBLE   = '0,
    parameter bit          SKID      = 1'b1,
    parameter bit          FLUSH_PRI = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data,
    input  logic         stall,
    input  logic         flush,
    output logic [1:0]   occupancy
);

    logic [W-1:0] main_q;
    logic         main_valid;
    logic [W-1:0] skid_q;
    logic         skid_valid;

    logic kill;
    logic acc;
    logic emt;

    // Without flush priority a flush requested during a stall waits for the stall to drop.
    assign kill = flush & (FLUSH_PRI | ~stall);

    generate
        if (SKID) begin : g_ready_skid
            // Depends only on flops and the local stall/flush controls, never on out_ready.
            assign in_ready = ~skid_valid & ~stall & ~kill & ~rst;
        end else begin : g_ready_single
            assign in_ready = (~main_valid | out_ready) & ~stall & ~kill & ~rst;
        end
    endgenerate

    assign acc = in_valid & in_ready;
    assign emt = main_valid & out_ready & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            main_q     <= BUBBLE;
            skid_q     <= BUBBLE;
        end else if (kill) begin
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (!SKID) begin
            if (acc) begin
                main_q     <= in_data;
                main_valid <= 1'b1;
            end else if (emt) begin
                main_valid <= 1'b0;
            end
        end else begin
            if (!main_valid) begin
                if (acc) begin
                    main_q     <= in_data;
                    main_valid <= 1'b1;
                end
            end else if (emt) begin
                if (skid_valid) begin
                    // Skid entry is older than anything arriving now, so it moves up first.
                    main_q <= skid_q;
                    if (acc) begin
                        skid_q <= in_data;
                    end else begin
                        skid_valid <= 1'b0;
                    end
                end else if (acc) begin
                    main_q <= in_data;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (acc) begin
                skid_q     <= in_data;
                skid_valid <= 1'b1;
            end
        end
    end

    assign out_valid = main_valid;
    assign out_data  = main_valid ? main_q : BUBBLE;
    assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three configurations (skid/no flush priority, skid/flush priority,
// single register) exercised one at a time against an expected-data queue.
module tb_pipe_stage_buf;

    localparam logic [31:0] BUB = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        in_valid  [3];
    logic        in_ready  [3];
    logic [31:0] in_data   [3];
    logic        out_valid [3];
    logic        out_ready [3];
    logic [31:0] out_data  [3];
    logic        stall     [3];
    logic        flush     [3];
    logic [1:0]  occupancy [3];

    logic [31:0] exp_q[$];
    int          total;
    int          bad;
    int          cur;

    pipe_stage_buf #(.W(32), .BUBBLE(BUB), .SKID(1'b1), .FLUSH_PRI(1'b0)) dut_a (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
        .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
        .stall(stall[0]), .flush(flush[0]), .occupancy(occupancy[0])
    );

    pipe_stage_buf #(.W(32), .BUBBLE(BUB), .SKID(1'b1), .FLUSH_PRI(1'b1)) dut_b (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
        .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
        .stall(stall[1]), .flush(flush[1]), .occupancy(occupancy[1])
    );

    pipe_stage_buf #(.W(32), .BUBBLE(BUB), .SKID(1'b0), .FLUSH_PRI(1'b0)) dut_c (
        .clk(clk), .rst(rst),
        .in_valid(in_valid[2]), .in_ready(in_ready[2]), .in_data(in_data[2]),
        .out_valid(out_valid[2]), .out_ready(out_ready[2]), .out_data(out_data[2]),
        .stall(stall[2]), .flush(flush[2]), .occupancy(occupancy[2])
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h (inst %0d, t=%0t)", tag, got, exp, cur, $time);
        end
    endtask

    // Scoreboard: pop on every emit of the active instance, push on every accept.
    always @(negedge clk) begin
        if (!rst) begin
            if (out_valid[cur] && out_ready[cur] && !stall[cur]) begin
                if (exp_q.size() == 0) check("sb_extra", exp_q.size(), 1);
                else                   check("sb_data", out_data[cur], exp_q.pop_front());
            end
            if (in_valid[cur] && in_ready[cur]) exp_q.push_back(in_data[cur]);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        for (int i = 0; i < 3; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = '0;
            out_ready[i] = 1'b0;
            stall[i]     = 1'b0;
            flush[i]     = 1'b0;
        end
    endtask

    task automatic send(input int i, input logic [31:0] d);
        logic took;
        took = 1'b0;
        in_valid[i] = 1'b1;
        in_data[i]  = d;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            took = in_ready[i];
            cyc();
            if (took) break;
        end
        if (!took) check("send_timeout", {31'b0, took}, 1);
        in_valid[i] = 1'b0;
    endtask

    task automatic drain(input int i);
        in_valid[i]  = 1'b0;
        stall[i]     = 1'b0;
        flush[i]     = 1'b0;
        out_ready[i] = 1'b1;
        for (int k = 0; k < 30; k++) begin
            cyc();
            if (exp_q.size() == 0 && !out_valid[i]) break;
        end
        check("drain_left", exp_q.size(), 0);
        check("drain_valid", {31'b0, out_valid[i]}, 0);
        out_ready[i] = 1'b0;
    endtask

    task automatic check_reset_state();
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            cur = i;
            check("rst_out_valid", {31'b0, out_valid[i]}, 0);
            check("rst_out_data", out_data[i], BUB);
            check("rst_occupancy", {30'b0, occupancy[i]}, 0);
            check("rst_in_ready", {31'b0, in_ready[i]}, 1);
        end
        cur = 0;
    endtask

    task automatic stream_test(input int i);
        cur = i;
        out_ready[i] = 1'b1;
        for (int d = 1; d <= 4; d++) begin
            in_valid[i] = 1'b1;
            in_data[i]  = d;
            @(negedge clk);
            check("stream_in_ready", {31'b0, in_ready[i]}, 1);
            if (d > 1) begin
                check("stream_valid", {31'b0, out_valid[i]}, 1);
                check("stream_data", out_data[i], d - 1);
            end
            cyc();
        end
        in_valid[i] = 1'b0;
        @(negedge clk);
        check("stream_last", out_data[i], 4);
        drain(i);
    endtask

    task automatic stall_test(input int i);
        cur = i;
        out_ready[i] = 1'b0;
        send(i, 32'd7);
        stall[i]     = 1'b1;
        out_ready[i] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stall_data", out_data[i], 7);
            check("stall_valid", {31'b0, out_valid[i]}, 1);
            check("stall_in_ready", {31'b0, in_ready[i]}, 0);
            cyc();
        end
        stall[i] = 1'b0;
        @(negedge clk);
        check("unstall_valid", {31'b0, out_valid[i]}, 1);
        cyc();
        @(negedge clk);
        check("emit_once_valid", {31'b0, out_valid[i]}, 0);
        check("emit_once_bubble", out_data[i], BUB);
        drain(i);
    endtask

    task automatic random_test(input int i, input int n);
        bit done;
        cur = i;
        done = 1'b0;
        fork
            begin
                for (int k = 0; k < n; k++) send(i, $urandom());
                done = 1'b1;
            end
            begin
                for (int k = 0; k < 2000 && !done; k++) begin
                    out_ready[i] = ($urandom_range(0, 3) != 0);
                    stall[i]     = ($urandom_range(0, 7) == 0);
                    cyc();
                end
            end
        join
        drain(i);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        cur   = 0;
        idle_inputs();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;
        check_reset_state();
        cyc();

        stream_test(0);

        // Backpressure into the skid entry.
        cur = 0;
        out_ready[0] = 1'b0;
        send(0, 32'd5);
        send(0, 32'd6);
        in_valid[0] = 1'b1;
        in_data[0]  = 32'd8;
        @(negedge clk);
        check("bp_occupancy", {30'b0, occupancy[0]}, 2);
        check("bp_in_ready", {31'b0, in_ready[0]}, 0);
        check("bp_head", out_data[0], 5);
        cyc();
        out_ready[0] = 1'b1;
        send(0, 32'd8);
        drain(0);

        stall_test(0);

        // Flush blocked by stall when flush has no priority.
        cur = 0;
        out_ready[0] = 1'b0;
        send(0, 32'd5);
        send(0, 32'd6);
        stall[0] = 1'b1;
        flush[0] = 1'b1;
        @(negedge clk);
        check("flush_blocked_in_ready", {31'b0, in_ready[0]}, 0);
        cyc();
        @(negedge clk);
        check("flush_blocked_occ", {30'b0, occupancy[0]}, 2);
        check("flush_blocked_data", out_data[0], 5);
        flush[0] = 1'b0;
        stall[0] = 1'b0;
        drain(0);

        // Flush overrides stall.
        cur = 1;
        out_ready[1] = 1'b0;
        send(1, 32'd5);
        send(1, 32'd6);
        stall[1] = 1'b1;
        flush[1] = 1'b1;
        @(negedge clk);
        check("flush_pri_in_ready", {31'b0, in_ready[1]}, 0);
        cyc();
        exp_q.delete();
        @(negedge clk);
        check("flush_pri_valid", {31'b0, out_valid[1]}, 0);
        check("flush_pri_occ", {30'b0, occupancy[1]}, 0);
        check("flush_pri_data", out_data[1], BUB);
        drain(1);

        // Unstalled flush on the single-register variant.
        cur = 2;
        send(2, 32'd11);
        flush[2] = 1'b1;
        cyc();
        exp_q.delete();
        flush[2] = 1'b0;
        @(negedge clk);
        check("flush_c_valid", {31'b0, out_valid[2]}, 0);
        drain(2);

        stream_test(2);
        stall_test(2);

        random_test(0, 40);
        random_test(1, 40);
        random_test(2, 40);

        // Reset dominates flush, stall and incoming data.
        cur = 0;
        out_ready[0] = 1'b0;
        send(0, 32'd21);
        for (int i = 0; i < 3; i++) begin
            flush[i]    = 1'b1;
            stall[i]    = 1'b1;
            in_valid[i] = 1'b1;
            in_data[i]  = 32'hABCD_0000 + i;
        end
        rst = 1'b1;
        @(negedge clk);
        check("rst_blocks_ready", {31'b0, in_ready[0]}, 0);
        cyc();
        cyc();
        exp_q.delete();
        idle_inputs();
        rst = 1'b0;
        check_reset_state();
        cyc();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
